// File: rtl/uart_tx_seq_pkg.sv
// Shared types for the UART TX message sequencer.
package uart_tx_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_START,
    WAIT_DONE,
    CHK,
    FINISH
  } state_t;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/uart_tx_sequencer.sv
// Splits one message of up to MAX_BYTES bytes into UART_TX byte handshakes, LSB byte first.
// Optional trailing XOR checksum byte when UART_TX_SEQ_CHKSUM_EN is defined.
module uart_tx_sequencer
  import uart_tx_seq_pkg::*;
#(
  parameter int MAX_BYTES = 2,
  parameter int LEN_W     = $clog2(MAX_BYTES) + 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [MAX_BYTES*8-1:0] MSG_DATA,
  input  logic [LEN_W-1:0]       MSG_LEN,
  input  logic                   MSG_VALID,
  output logic                   MSG_READY,
  output logic                   MSG_DONE,
  output logic [7:0]             TX_P_DATA,
  output logic                   TX_D_VLD,
  input  logic                   TX_BUSY
);

  state_t                 state_reg;
  state_t                 state_next;
  logic [MAX_BYTES*8-1:0] msg_reg;
  logic [LEN_W-1:0]       len_reg;
  logic [LEN_W-1:0]       len_clamped;
  logic [LEN_W-1:0]       idx_reg;
  logic [LEN_W-1:0]       idx_next;
  byte_t                  hold_reg;
  byte_t                  cur_byte;
  byte_t                  tx_byte;
  byte_t                  msg_bytes [MAX_BYTES];
  logic                   accept;
  logic                   strobe;
  logic                   last_byte;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_BYTES; gi++) begin : g_bytes
      assign msg_bytes[gi] = msg_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (idx_reg == LEN_W'(i)) cur_byte = msg_bytes[i];
    end
  end

  assign len_clamped = (MSG_LEN > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : MSG_LEN;
  assign accept      = MSG_VALID && (state_reg == IDLE);
  assign last_byte   = (idx_reg == len_reg - LEN_W'(1));

`ifdef UART_TX_SEQ_CHKSUM_EN
  byte_t chk_reg;
  logic  chk_phase_reg;

  assign tx_byte = (state_reg == CHK) ? chk_reg : cur_byte;

  // chk_phase_reg marks that the frame in flight is the checksum, so WAIT_DONE ends the message.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      chk_reg       <= '0;
      chk_phase_reg <= 1'b0;
    end else if (accept) begin
      chk_reg       <= '0;
      chk_phase_reg <= 1'b0;
    end else if (strobe) begin
      if (state_reg == CHK) chk_phase_reg <= 1'b1;
      else                  chk_reg       <= chk_reg ^ cur_byte;
    end
  end
`else
  assign tx_byte = cur_byte;
`endif

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    strobe     = 1'b0;
    case (state_reg)
      IDLE: begin
        idx_next = '0;
        // Zero-length requests also pass through SEND, which skips straight to FINISH.
        if (MSG_VALID) state_next = SEND;
      end
      SEND: begin
        if (len_reg == '0) begin
          state_next = FINISH;
        end else if (!TX_BUSY) begin
          strobe     = 1'b1;
          state_next = WAIT_START;
        end
      end
      WAIT_START: begin
        if (TX_BUSY) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!TX_BUSY) begin
`ifdef UART_TX_SEQ_CHKSUM_EN
          if (chk_phase_reg) begin
            state_next = FINISH;
          end else if (last_byte) begin
            state_next = CHK;
          end else begin
`else
          if (last_byte) begin
            state_next = FINISH;
          end else begin
`endif
            idx_next   = idx_reg + LEN_W'(1);
            state_next = SEND;
          end
        end
      end
      CHK: begin
`ifdef UART_TX_SEQ_CHKSUM_EN
        if (!TX_BUSY) begin
          strobe     = 1'b1;
          state_next = WAIT_START;
        end
`else
        state_next = IDLE;
`endif
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= IDLE;
      msg_reg   <= '0;
      len_reg   <= '0;
      idx_reg   <= '0;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (accept) begin
        msg_reg <= MSG_DATA;
        len_reg <= len_clamped;
      end
      if (strobe) hold_reg <= tx_byte;
    end
  end

  // The strobed byte is shown combinationally and then held until the next strobe.
  assign TX_P_DATA = strobe ? tx_byte : hold_reg;
  assign TX_D_VLD  = strobe;
  assign MSG_READY = (state_reg == IDLE);
  assign MSG_DONE  = (state_reg == FINISH);

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Self-checking bench for uart_tx_sequencer with a cycle-counting UART_TX BUSY model.
// Expected checksum byte is included when UART_TX_SEQ_CHKSUM_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx_sequencer;
  import uart_tx_seq_pkg::*;

  localparam int MAX_BYTES = 2;
  localparam int LEN_W     = $clog2(MAX_BYTES) + 1;

  logic                   CLK = 1'b0;
  logic                   RST;
  logic [MAX_BYTES*8-1:0] MSG_DATA;
  logic [LEN_W-1:0]       MSG_LEN;
  logic                   MSG_VALID;
  logic                   MSG_READY;
  logic                   MSG_DONE;
  logic [7:0]             TX_P_DATA;
  logic                   TX_D_VLD;
  logic                   TX_BUSY;

  int tests_run    = 0;
  int tests_failed = 0;

  uart_tx_sequencer #(.MAX_BYTES(MAX_BYTES), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RST(RST), .MSG_DATA(MSG_DATA), .MSG_LEN(MSG_LEN), .MSG_VALID(MSG_VALID),
    .MSG_READY(MSG_READY), .MSG_DONE(MSG_DONE), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .TX_BUSY(TX_BUSY)
  );

  always #5 CLK = ~CLK;

  // UART_TX model: BUSY high for frame_len cycles after each accepted strobe.
  int   frame_len  = 11;
  int   busy_cnt   = 0;
  logic force_busy = 1'b0;
  always @(posedge CLK) begin
    if (busy_cnt > 0)  busy_cnt <= busy_cnt - 1;
    else if (TX_D_VLD) busy_cnt <= frame_len;
  end
  assign TX_BUSY = (busy_cnt != 0) || force_busy;

  // Monitor
  int    cyc = 0;
  int    strobe_cyc_q[$];
  byte_t strobe_dat_q[$];
  int    done_q[$];
  int    viol_cnt = 0;
  int    hold_err = 0;
  int    wide_cnt = 0;
  byte_t last_data = 8'h00;
  logic  vld_prev = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (TX_D_VLD) begin
      strobe_cyc_q.push_back(cyc);
      strobe_dat_q.push_back(TX_P_DATA);
    end
    if (MSG_DONE) done_q.push_back(cyc);
    if (TX_D_VLD && TX_BUSY) viol_cnt++;
    if (TX_D_VLD && vld_prev) wide_cnt++;
    vld_prev = TX_D_VLD;
    if (!RST)                        last_data = 8'h00;
    else if (TX_D_VLD)               last_data = TX_P_DATA;
    else if (TX_P_DATA !== last_data) hold_err++;
  end

  // Reference model: payload bytes LSB first, length clamped, optional XOR byte.
  byte_t exp_q[$];
  function automatic void model(input logic [MAX_BYTES*8-1:0] data, input int len);
    int n;
    n = (len > MAX_BYTES) ? MAX_BYTES : len;
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(data[8*k +: 8]);
`ifdef UART_TX_SEQ_CHKSUM_EN
    if (n > 0) begin
      byte_t x;
      x = 8'h00;
      for (int k = 0; k < n; k++) x = x ^ exp_q[k];
      exp_q.push_back(x);
    end
`endif
  endfunction

  task automatic send_msg(input logic [MAX_BYTES*8-1:0] data, input logic [LEN_W-1:0] len,
                          output int acc);
    int guard;
    strobe_cyc_q.delete();
    strobe_dat_q.delete();
    done_q.delete();
    @(negedge CLK);
    guard = 0;
    while (!MSG_READY && guard < 200) begin
      @(negedge CLK);
      guard++;
    end
    MSG_DATA  = data;
    MSG_LEN   = len;
    MSG_VALID = 1'b1;
    acc       = cyc;
    @(posedge CLK);
    #1;
    MSG_VALID = 1'b0;
    MSG_DATA  = MAX_BYTES*8'($urandom);
    MSG_LEN   = LEN_W'($urandom);
  endtask

  task automatic wait_done(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge CLK);
      #1;
      if (done_q.size() > 0) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    tests_run++;
    if (MSG_READY !== 1'b1 || MSG_DONE !== 1'b0 || TX_D_VLD !== 1'b0 || TX_P_DATA !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_values: ready=%b done=%b vld=%b data=%h, want 1 0 0 00",
               MSG_READY, MSG_DONE, TX_D_VLD, TX_P_DATA);
    end
    @(negedge CLK);
    RST = 1'b1;
    $display("[TB] reset released at cycle %0d", cyc);
  endtask

  task automatic test_basic();
    int acc;
    bit seen;
    frame_len = 11;
    model(16'hA55A, 2);
    send_msg(16'hA55A, 2'd2, acc);
    wait_done(300, seen);
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL basic_done_seen: got none, want pulse"); end
    tests_run++;
    if (strobe_dat_q.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL basic_count: got %0d strobes, want %0d", strobe_dat_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < strobe_dat_q.size(); k++) begin
      tests_run++;
      if (strobe_dat_q[k] !== exp_q[k] || strobe_cyc_q[k] !== acc + 1 + k*(frame_len+2)) begin
        tests_failed++;
        $display("FAIL basic_byte%0d: got %h@%0d, want %h@%0d", k, strobe_dat_q[k], strobe_cyc_q[k],
                 exp_q[k], acc + 1 + k*(frame_len+2));
      end
    end
    if (seen) begin
      tests_run++;
      if (done_q[0] !== acc + 1 + exp_q.size()*(frame_len+2) || MSG_READY !== 1'b0) begin
        tests_failed++;
        $display("FAIL basic_done: got @%0d ready=%b, want @%0d ready=0", done_q[0], MSG_READY,
                 acc + 1 + exp_q.size()*(frame_len+2));
      end
    end
    @(negedge CLK);
    #1;
    tests_run++;
    if (MSG_READY !== 1'b1) begin tests_failed++; $display("FAIL basic_ready_after: got 0, want 1"); end
    $display("[TB] basic A55A: %0d strobes, done at %0d", strobe_dat_q.size(), seen ? done_q[0] : -1);
  endtask

  task automatic test_len_zero();
    int acc;
    bit seen;
    send_msg(MAX_BYTES*8'($urandom), 2'd0, acc);
    wait_done(50, seen);
    tests_run++;
    if (!seen || done_q[0] !== acc + 2) begin
      tests_failed++;
      $display("FAIL len0_done: got seen=%b @%0d, want @%0d", seen, seen ? done_q[0] : -1, acc + 2);
    end
    @(negedge CLK);
    #1;
    tests_run++;
    if (MSG_READY !== 1'b1 || cyc !== acc + 3) begin
      tests_failed++;
      $display("FAIL len0_ready: got ready=%b @%0d, want 1 @%0d", MSG_READY, cyc, acc + 3);
    end
    tests_run++;
    if (strobe_dat_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL len0_no_strobe: got %0d strobes, want 0", strobe_dat_q.size());
    end
    $display("[TB] len=0: done at %0d (accept %0d)", seen ? done_q[0] : -1, acc);
  endtask

  task automatic test_clamp();
    int acc;
    bit seen;
    frame_len = 4;
    model(16'h1234, 3);
    send_msg(16'h1234, 2'd3, acc);
    wait_done(200, seen);
    tests_run++;
    if (!seen || strobe_dat_q.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL clamp_count: got seen=%b %0d strobes, want %0d", seen, strobe_dat_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < strobe_dat_q.size(); k++) begin
      tests_run++;
      if (strobe_dat_q[k] !== exp_q[k]) begin
        tests_failed++;
        $display("FAIL clamp_byte%0d: got %h, want %h", k, strobe_dat_q[k], exp_q[k]);
      end
    end
    $display("[TB] clamp len=3: %0d strobes", strobe_dat_q.size());
  endtask

  task automatic test_busy_hold();
    int acc;
    int rel;
    bit seen;
    logic [15:0] d;
    frame_len = 5;
    d = 16'($urandom);
    model(d, 1);
    @(negedge CLK);
    force_busy = 1'b1;
    send_msg(d, 2'd1, acc);
    repeat (20) @(negedge CLK);
    #1;
    tests_run++;
    if (strobe_dat_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL busy_hold_quiet: got %0d strobes, want 0", strobe_dat_q.size());
    end
    @(posedge CLK);
    #1;
    force_busy = 1'b0;
    rel = cyc;
    wait_done(100, seen);
    tests_run++;
    if (strobe_dat_q.size() < 1 || strobe_cyc_q[0] !== rel || strobe_dat_q[0] !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL busy_hold_strobe: got %0d strobes first@%0d, want %h@%0d", strobe_dat_q.size(),
               strobe_cyc_q.size() > 0 ? strobe_cyc_q[0] : -1, exp_q[0], rel);
    end
    tests_run++;
    if (!seen || done_q[0] !== rel + exp_q.size()*(frame_len+2)) begin
      tests_failed++;
      $display("FAIL busy_hold_done: got @%0d, want @%0d", seen ? done_q[0] : -1,
               rel + exp_q.size()*(frame_len+2));
    end
    $display("[TB] busy hold: released %0d, strobe %0d", rel, strobe_cyc_q.size() > 0 ? strobe_cyc_q[0] : -1);
  endtask

  task automatic test_reset_mid();
    int acc;
    int guard;
    bit seen;
    logic [15:0] d;
    frame_len = 11;
    send_msg(16'hBEEF, 2'd2, acc);
    guard = 0;
    while (strobe_dat_q.size() < 1 && guard < 50) begin @(negedge CLK); guard++; end
    repeat (4) @(negedge CLK);
    #1;
    RST = 1'b0;
    #1;
    tests_run++;
    if (MSG_READY !== 1'b1 || MSG_DONE !== 1'b0 || TX_D_VLD !== 1'b0 || TX_P_DATA !== 8'h00) begin
      tests_failed++;
      $display("FAIL mid_reset_values: ready=%b done=%b vld=%b data=%h, want 1 0 0 00",
               MSG_READY, MSG_DONE, TX_D_VLD, TX_P_DATA);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    guard = 0;
    while (TX_BUSY && guard < 50) begin @(negedge CLK); guard++; end
    #1;
    tests_run++;
    if (done_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL mid_reset_no_done: got %0d pulses, want 0", done_q.size());
    end
    d = 16'($urandom);
    model(d, 2);
    send_msg(d, 2'd2, acc);
    wait_done(300, seen);
    tests_run++;
    if (!seen || strobe_dat_q.size() !== exp_q.size() || strobe_dat_q[0] !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL mid_reset_resend: got seen=%b n=%0d first=%h, want n=%0d first=%h", seen,
               strobe_dat_q.size(), strobe_dat_q.size() > 0 ? strobe_dat_q[0] : 8'h00, exp_q.size(), exp_q[0]);
    end
    $display("[TB] reset mid-message then resend %h", d);
  endtask

  task automatic test_back_to_back();
    int acc1;
    int acc2;
    int d1;
    bit seen;
    logic [15:0] d;
    frame_len = 3;
    send_msg(16'($urandom), 2'd2, acc1);
    wait_done(200, seen);
    d1 = seen ? done_q[0] : -100;
    d = 16'($urandom);
    model(d, 1);
    send_msg(d, 2'd1, acc2);
    tests_run++;
    if (acc2 !== d1 + 1) begin
      tests_failed++;
      $display("FAIL b2b_accept: got accept @%0d, want @%0d", acc2, d1 + 1);
    end
    wait_done(200, seen);
    tests_run++;
    if (!seen || strobe_dat_q.size() !== exp_q.size() || strobe_dat_q[0] !== exp_q[0] ||
        strobe_cyc_q[0] !== acc2 + 1) begin
      tests_failed++;
      $display("FAIL b2b_second: got seen=%b n=%0d first=%h, want n=%0d first=%h@%0d", seen,
               strobe_dat_q.size(), strobe_dat_q.size() > 0 ? strobe_dat_q[0] : 8'h00,
               exp_q.size(), exp_q[0], acc2 + 1);
    end
    $display("[TB] back-to-back: first done %0d, second accept %0d", d1, acc2);
  endtask

  task automatic test_random();
    int acc;
    int len;
    int exp_done;
    bit seen;
    logic [15:0] d;
    for (int t = 0; t < 15; t++) begin
      frame_len = $urandom_range(1, 12);
      len = $urandom_range(0, 3);
      d = 16'($urandom);
      model(d, len);
      send_msg(d, LEN_W'(len), acc);
      wait_done(400, seen);
      exp_done = (exp_q.size() == 0) ? acc + 2 : acc + 1 + exp_q.size()*(frame_len+2);
      tests_run++;
      if (strobe_dat_q.size() !== exp_q.size()) begin
        tests_failed++;
        $display("FAIL rand%0d_count: got %0d, want %0d", t, strobe_dat_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < strobe_dat_q.size(); k++) begin
        tests_run++;
        if (strobe_dat_q[k] !== exp_q[k] || strobe_cyc_q[k] !== acc + 1 + k*(frame_len+2)) begin
          tests_failed++;
          $display("FAIL rand%0d_byte%0d: got %h@%0d, want %h@%0d", t, k, strobe_dat_q[k],
                   strobe_cyc_q[k], exp_q[k], acc + 1 + k*(frame_len+2));
        end
      end
      tests_run++;
      if (!seen || done_q[0] !== exp_done) begin
        tests_failed++;
        $display("FAIL rand%0d_done: got @%0d, want @%0d", t, seen ? done_q[0] : -1, exp_done);
      end
      $display("[TB] rand%0d data=%h len=%0d frame=%0d strobes=%0d", t, d, len, frame_len, strobe_dat_q.size());
    end
  endtask

  task automatic test_protocol();
    tests_run++;
    if (viol_cnt !== 0) begin tests_failed++; $display("FAIL vld_while_busy: got %0d, want 0", viol_cnt); end
    tests_run++;
    if (wide_cnt !== 0) begin tests_failed++; $display("FAIL strobe_width: got %0d wide, want 0", wide_cnt); end
    tests_run++;
    if (hold_err !== 0) begin tests_failed++; $display("FAIL data_hold: got %0d changes, want 0", hold_err); end
  endtask

  initial begin
    RST       = 1'b0;
    MSG_VALID = 1'b0;
    MSG_DATA  = '0;
    MSG_LEN   = '0;
    test_reset();
    test_basic();
    test_len_zero();
    test_clamp();
    test_busy_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
